// File: rtl/mul_seq_if.sv
// mul_seq_if: EX-stage <-> multiply sequencer signal bundle.
//   master : EX stage side (drives request, operands, flush; sees stall/result)
//   slave  : mul_seq side
//   start_i/flush_i/op_i/rs1_i/rs2_i : request from EX
//   stallreq_o/busy_o/valid_o/result_o : status and result back to EX
interface mul_seq_if #(
  parameter int XLEN = 32
) ();
  logic            start_i;
  logic            flush_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            stallreq_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, flush_i, op_i, rs1_i, rs2_i,
    input  stallreq_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, flush_i, op_i, rs1_i, rs2_i,
    output stallreq_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier for the EX stage.
// Handles MUL/MULH/MULHSU/MULHU by multiplying operand magnitudes and
// negating the 2*XLEN-bit product at the end when the signs differ.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous reset, active low
//   bus   - mul_seq_if.slave: start/flush/op/rs1/rs2 in,
//           stallreq/busy/valid/result out
// Timing: start accepted in cycle 0, N = XLEN/RADIX_BITS CALC cycles,
// one-cycle valid pulse in cycle N+1, stall request held cycles 0..N.
module mul_seq #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);

  localparam int N     = XLEN / RADIX_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [1:0]             op_r;
  logic                   neg_r;
  logic [XLEN-1:0]        mcand_r;
  logic [XLEN-1:0]        mplr_r;
  logic [PW-1:0]          acc_r;
  logic [CNT_W-1:0]       count_r;
  logic [XLEN-1:0]        result_r;

  logic                   accept_s;
  logic                   last_s;
  logic                   stallreq_s;
  logic                   valid_s;
  logic                   sign1_s;
  logic                   sign2_s;
  logic [SH_W-1:0]        shamt_s;
  logic [XLEN+RADIX_BITS-1:0] pp_s;
  logic [PW-1:0]          acc_nxt_s;
  logic [PW-1:0]          prod_s;
  logic [XLEN-1:0]        result_nxt_s;

  // Two's-complement magnitude of a value whose sign is s.
  // 0x80000000 maps onto itself, which is correct when read as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic s);
    logic [XLEN-1:0] m;
    if (s) begin
      m = ~x + XLEN'(1);
    end else begin
      m = x;
    end
    return m;
  endfunction

  // Operand signedness, partial product and final product selection.
  always_comb begin
    accept_s = bus.start_i & ~bus.flush_i;
    last_s   = (count_r == CNT_W'(N - 1));
    // rs1 is signed for all but MULHU; rs2 only for MUL/MULH.
    sign1_s  = (bus.op_i != 2'b11) & bus.rs1_i[XLEN-1];
    sign2_s  = (bus.op_i[1] == 1'b0) & bus.rs2_i[XLEN-1];
    shamt_s  = SH_W'(32'(count_r) * RADIX_BITS);
    pp_s     = {{RADIX_BITS{1'b0}}, mcand_r} * {{XLEN{1'b0}}, mplr_r[RADIX_BITS-1:0]};
    acc_nxt_s = acc_r + ({{(XLEN-RADIX_BITS){1'b0}}, pp_s} << shamt_s);
    if (neg_r) begin
      prod_s = ~acc_nxt_s + PW'(1);
    end else begin
      prod_s = acc_nxt_s;
    end
    if (op_r == 2'b00) begin
      result_nxt_s = prod_s[XLEN-1:0];
    end else begin
      result_nxt_s = prod_s[PW-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake outputs; flush wins over everything in flight.
  always_comb begin
    state_nxt_s = state_r;
    stallreq_s  = 1'b0;
    valid_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          stallreq_s  = 1'b1;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_nxt_s = IDLE;
        end else begin
          stallreq_s = 1'b1;
          if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        if (bus.flush_i) begin
          valid_s = 1'b0;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand latch and shift-add iteration; result captured on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      neg_r    <= 1'b0;
      mcand_r  <= {XLEN{1'b0}};
      mplr_r   <= {XLEN{1'b0}};
      acc_r    <= {PW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r    <= bus.op_i;
            neg_r   <= sign1_s ^ sign2_s;
            mcand_r <= magnitude(bus.rs1_i, sign1_s);
            mplr_r  <= magnitude(bus.rs2_i, sign2_s);
            acc_r   <= {PW{1'b0}};
            count_r <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          if (!bus.flush_i) begin
            acc_r   <= acc_nxt_s;
            mplr_r  <= mplr_r >> RADIX_BITS;
            count_r <= count_r + CNT_W'(1);
            if (last_s) begin
              result_r <= result_nxt_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stallreq_o = stallreq_s;
  assign bus.busy_o     = (state_r != IDLE);
  assign bus.valid_o    = valid_s;
  assign bus.result_o   = valid_s ? result_r : {XLEN{1'b0}};

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and randomized checks of mul_seq with RADIX_BITS=1
// (dut1) and RADIX_BITS=4 (dut4). Inputs change 1 time unit after the
// rising edge, outputs are sampled 1 unit later.
module tb_mul_seq;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   check_cnt;

  mul_seq_if #(.XLEN(XLEN)) bus1 ();
  mul_seq_if #(.XLEN(XLEN)) bus4 ();

  mul_seq #(.XLEN(XLEN), .RADIX_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mul_seq #(.XLEN(XLEN), .RADIX_BITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic st, input logic fl, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      bus4.start_i = st; bus4.flush_i = fl; bus4.op_i = op; bus4.rs1_i = a; bus4.rs2_i = b;
    end else begin
      bus1.start_i = st; bus1.flush_i = fl; bus1.op_i = op; bus1.rs1_i = a; bus1.rs2_i = b;
    end
  endtask

  // {stallreq, busy, valid, result}
  function automatic logic [34:0] outs(input bit sel);
    if (sel) return {bus4.stallreq_o, bus4.busy_o, bus4.valid_o, bus4.result_o};
    else     return {bus1.stallreq_o, bus1.busy_o, bus1.valid_o, bus1.result_o};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] xa;
    logic signed [32:0] xb;
    logic signed [65:0] p;
    xa = {(op != 2'b11) & a[31], a};
    xb = {(op == 2'b00 || op == 2'b01) & b[31], b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op starting at the next edge; operands are scrambled after
  // acceptance. Leaves start_i high, returning in the valid cycle.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
    int n;
    int got;
    int stalls;
    logic [34:0] o;
    n = sel ? 8 : 32;
    got = -1;
    stalls = 0;
    tick();
    drive(sel, 1'b1, 1'b0, op, a, b);
    #1;
    o = outs(sel);
    chk({tag, " stall_c0"}, 32'(o[34]), 32'd1);
    for (int c = 1; c <= n + 4; c++) begin
      tick();
      if (c == 1) drive(sel, 1'b1, 1'b0, ~op, ~a, ~b);
      #1;
      o = outs(sel);
      if (o[34]) stalls++;
      if (o[32]) begin
        got = c;
        break;
      end
    end
    chk({tag, " latency"}, 32'(got), 32'(n + 1));
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(n));
    chk({tag, " result"}, o[31:0], exp);
  endtask

  task automatic go_idle(input bit sel);
    tick();
    drive(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  // Protocol monitor: start_i must stay high while CALC runs unflushed.
  always @(negedge clk) begin
    assert (!(rst_n && bus1.busy_o && bus1.stallreq_o && !bus1.start_i && !bus1.flush_i))
    else begin check_cnt++; $error("FAIL protocol1: start_i dropped in CALC"); end
    assert (!(rst_n && bus4.busy_o && bus4.stallreq_o && !bus4.start_i && !bus4.flush_i))
    else begin check_cnt++; $error("FAIL protocol4: start_i dropped in CALC"); end
  end

  initial begin
    logic [34:0] o;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int vcount;
    pass_cnt  = 0;
    check_cnt = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #2;
    o = outs(1'b0);
    chk("rst stallreq", 32'(o[34]), 32'd0);
    chk("rst busy",     32'(o[33]), 32'd0);
    chk("rst valid",    32'(o[32]), 32'd0);
    chk("rst result",   o[31:0],    32'h0);
    #10 rst_n = 1'b1;

    // MUL 7 x -3 with full cycle-by-cycle timing
    run_op(1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
    o = outs(1'b0);
    chk("mul_7x-3 stall_in_done", 32'(o[34]), 32'd0);
    go_idle(1'b0);
    #1;
    o = outs(1'b0);
    chk("mul_7x-3 busy_c34",  32'(o[33]), 32'd0);
    chk("mul_7x-3 valid_c34", 32'(o[32]), 32'd0);

    // Signedness corners
    run_op(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    go_idle(1'b0);
    run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    go_idle(1'b0);
    run_op(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    go_idle(1'b0);

    // Back-to-back: second op accepted in the IDLE cycle right after DONE
    run_op(1'b0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, "b2b_first");
    run_op(1'b0, 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "b2b_second");
    go_idle(1'b0);

    // Flush in CALC cycle 10
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h1111, 32'h2222);
    for (int c = 1; c <= 9; c++) tick();
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'h1111, 32'h2222);
    #1;
    o = outs(1'b0);
    chk("flush stallreq", 32'(o[34]), 32'd0);
    chk("flush valid",    32'(o[32]), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    o = outs(1'b0);
    chk("flush busy_next", 32'(o[33]), 32'd0);
    chk("flush valid_next", 32'(o[32]), 32'd0);
    run_op(1'b0, 2'b00, 32'h1234_5678, 32'd1, 32'h1234_5678, "after_flush");
    go_idle(1'b0);

    // start and flush together in IDLE: no start
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'd9, 32'd9);
    #1;
    o = outs(1'b0);
    chk("idle_flush stallreq", 32'(o[34]), 32'd0);
    go_idle(1'b0);
    #1;
    o = outs(1'b0);
    chk("idle_flush busy", 32'(o[33]), 32'd0);

    // Async reset in CALC cycle 5
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'd6, 32'd7);
    for (int c = 1; c <= 5; c++) tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    o = outs(1'b0);
    chk("midrst stallreq", 32'(o[34]), 32'd0);
    chk("midrst busy",     32'(o[33]), 32'd0);
    chk("midrst valid",    32'(o[32]), 32'd0);
    chk("midrst result",   o[31:0],    32'h0);
    tick();
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #1;
      if (bus1.valid_o || bus1.busy_o) vcount++;
    end
    chk("midrst no_activity", 32'(vcount), 32'd0);

    // RADIX_BITS=4: random ops against the reference model
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        default: rb = $urandom;
      endcase
      run_op(1'b1, rop, ra, rb, ref_mul(rop, ra, rb), "rand_r4");
      if ($urandom_range(0, 1) == 0) go_idle(1'b1);
    end
    go_idle(1'b1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
